// File: rtl/i2c_seq_pkg.sv
// Shared types for the I2C master command sequencer: command codes, line-driver
// select, FSM states and ACK/NACK bit values.
package i2c_seq_pkg;

    typedef enum logic [1:0] {
        CMD_START = 2'd0,
        CMD_WRITE = 2'd1,
        CMD_READ  = 2'd2,
        CMD_STOP  = 2'd3
    } i2c_cmd_t;

    typedef enum logic [1:0] {
        LINE_REL  = 2'd0,
        LINE_SSG  = 2'd1,
        LINE_XFER = 2'd2
    } line_sel_t;

    typedef enum logic [2:0] {
        IDLE,
        GEN_START,
        GEN_STOP,
        XFER,
        RELEASE,
        RESP,
        ERR
    } seq_state_t;

    localparam logic ACK_BIT  = 1'b0;
    localparam logic NACK_BIT = 1'b1;

endpackage

// File: rtl/i2c_master_sequencer_if.sv
// Command/response handshake between the register interface (master) and the
// sequencer (slave).
interface i2c_master_sequencer_if;
    import i2c_seq_pkg::*;

    logic       cmd_valid;
    logic       cmd_ready;
    i2c_cmd_t   cmd_op;
    logic [7:0] cmd_data;
    logic       cmd_master_ack;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_nack;
    logic       rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_master_ack, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_nack, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_master_ack, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_nack, rsp_err
    );

endinterface

// File: rtl/flex_counter.sv
// Up-counter with synchronous clear; wraps back to 1 after reaching rollover_val.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out
);

    logic [NUM_CNT_BITS-1:0] count_reg;
    logic [NUM_CNT_BITS-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (count_enable) begin
            if (count_reg == rollover_val) begin
                count_next = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};
            end else begin
                count_next = count_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count_out = count_reg;

endmodule

// File: rtl/i2c_master_sequencer.sv
// Command-level I2C master controller: sequences the start/stop generator and the
// byte engine, tracks bus ownership and returns one response per command.
module i2c_master_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                  clk,
    input  logic                  rst,
    i2c_master_sequencer_if.slave cmd_bus,
    output logic                  bus_owned,
    output logic                  ssg_start,
    output logic                  ssg_stop,
    input  logic                  ssg_done,
    output logic                  xfer_req,
    output logic                  xfer_dir,
    output logic [7:0]            xfer_wdata,
    output logic                  xfer_ack_send,
    input  logic                  xfer_done,
    input  logic [7:0]            xfer_rdata,
    input  logic                  xfer_ack_rcvd,
    output line_sel_t             line_sel
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    seq_state_t state_reg, state_next;
    i2c_cmd_t   op_reg;
    logic [7:0] data_reg;
    logic       ack_reg;
    logic       bus_owned_reg;
    logic [7:0] rsp_data_reg;
    logic       rsp_nack_reg;
    logic       rsp_err_reg;
    line_sel_t  line_sel_reg, line_sel_next;
    logic [CW-1:0] tmo_count;

    logic accept, illegal, waiting, done_now, timeout_hit;

    assign accept   = cmd_bus.cmd_valid && cmd_bus.cmd_ready;
    assign illegal  = (cmd_bus.cmd_op != CMD_START) && !bus_owned_reg;
    assign waiting  = (state_reg == GEN_START) || (state_reg == GEN_STOP) || (state_reg == XFER);
    assign done_now = (state_reg == XFER) ? xfer_done : ssg_done;
    // Fires on the last permitted waiting cycle so the request is held exactly TIMEOUT_CYCLES cycles.
    assign timeout_hit = waiting && (tmo_count == CW'(TIMEOUT_CYCLES - 1));

    flex_counter #(.NUM_CNT_BITS(CW)) u_timeout (
        .clk          (clk),
        .srst         (rst),
        .clear        (!waiting),
        .count_enable (waiting),
        .rollover_val (CW'(TIMEOUT_CYCLES)),
        .count_out    (tmo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (cmd_bus.cmd_op == CMD_START) state_next = GEN_START;
                    else if (illegal)                state_next = ERR;
                    else if (cmd_bus.cmd_op == CMD_STOP) state_next = GEN_STOP;
                    else                             state_next = XFER;
                end
            end
            GEN_START, GEN_STOP, XFER: begin
                if (done_now || timeout_hit) state_next = RELEASE;
            end
            RELEASE: state_next = RESP;
            ERR:     state_next = RESP;
            RESP: begin
                if (cmd_bus.rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // While owned, the select keeps its last value so SCL stays held between bytes.
    always_comb begin
        line_sel_next = line_sel_reg;
        if ((state_next == GEN_START) || (state_next == GEN_STOP)) begin
            line_sel_next = LINE_SSG;
        end else if (state_next == XFER) begin
            line_sel_next = LINE_XFER;
        end else if ((state_next == IDLE) && !bus_owned_reg) begin
            line_sel_next = LINE_REL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_reg        <= CMD_START;
            data_reg      <= '0;
            ack_reg       <= ACK_BIT;
            bus_owned_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_nack_reg  <= 1'b0;
            rsp_err_reg   <= 1'b0;
            line_sel_reg  <= LINE_REL;
        end else begin
            line_sel_reg <= line_sel_next;
            if (accept) begin
                op_reg       <= cmd_bus.cmd_op;
                data_reg     <= cmd_bus.cmd_data;
                ack_reg      <= cmd_bus.cmd_master_ack;
                rsp_data_reg <= '0;
                rsp_nack_reg <= 1'b0;
                rsp_err_reg  <= illegal;
            end
            if (waiting) begin
                if (done_now) begin
                    if (state_reg == GEN_START) begin
                        bus_owned_reg <= 1'b1;
                    end else if (state_reg == GEN_STOP) begin
                        bus_owned_reg <= 1'b0;
                    end else if (op_reg == CMD_READ) begin
                        rsp_data_reg <= xfer_rdata;
                    end else begin
                        rsp_nack_reg <= xfer_ack_rcvd;
                    end
                end else if (timeout_hit) begin
                    bus_owned_reg <= 1'b0;
                    rsp_err_reg   <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        ssg_start         = (state_reg == GEN_START);
        ssg_stop          = (state_reg == GEN_STOP);
        xfer_req          = (state_reg == XFER);
        xfer_dir          = xfer_req && (op_reg == CMD_READ);
        xfer_wdata        = xfer_req ? data_reg : 8'h00;
        xfer_ack_send     = xfer_req && ack_reg;
        line_sel          = line_sel_reg;
        bus_owned         = bus_owned_reg;
        cmd_bus.cmd_ready = (state_reg == IDLE) && !rst;
        cmd_bus.rsp_valid = (state_reg == RESP);
        cmd_bus.rsp_data  = rsp_data_reg;
        cmd_bus.rsp_nack  = rsp_nack_reg;
        cmd_bus.rsp_err   = rsp_err_reg;
    end

endmodule

// File: tb/tb_i2c_master_sequencer.sv
// Table-driven bench for i2c_master_sequencer with a short timeout and a few
// hand-written reset / stray-done sequences.
module tb_i2c_master_sequencer;
    import i2c_seq_pkg::*;

    localparam int TMO = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       bus_owned, ssg_start, ssg_stop, ssg_done;
    logic       xfer_req, xfer_dir, xfer_ack_send, xfer_done, xfer_ack_rcvd;
    logic [7:0] xfer_wdata, xfer_rdata;
    line_sel_t  line_sel;

    i2c_master_sequencer_if bus ();

    i2c_master_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_bus       (bus),
        .bus_owned     (bus_owned),
        .ssg_start     (ssg_start),
        .ssg_stop      (ssg_stop),
        .ssg_done      (ssg_done),
        .xfer_req      (xfer_req),
        .xfer_dir      (xfer_dir),
        .xfer_wdata    (xfer_wdata),
        .xfer_ack_send (xfer_ack_send),
        .xfer_done     (xfer_done),
        .xfer_rdata    (xfer_rdata),
        .xfer_ack_rcvd (xfer_ack_rcvd),
        .line_sel      (line_sel)
    );

    typedef struct {
        int op, data, mack, done_at, rdata, ack_rcvd, hold;
        int exp_mask, exp_cycles, exp_err, exp_nack, exp_rdata, exp_owned, exp_line_req, exp_line_idle;
    } vec_t;

    vec_t vecs[14];
    int tests_run = 0;
    int tests_failed = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int idx, req_cycles, last, mask, line_req, dir_c, ack_c, wd_c, got;
        chk("cmd_ready_before", int'(bus.cmd_ready), 1);
        bus.cmd_valid      = 1'b1;
        bus.cmd_op         = i2c_cmd_t'(v.op[1:0]);
        bus.cmd_data       = v.data[7:0];
        bus.cmd_master_ack = v.mack[0];
        xfer_rdata         = v.rdata[7:0];
        xfer_ack_rcvd      = v.ack_rcvd[0];
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        req_cycles = 0; last = 0; mask = 0; got = 0; idx = 1;
        line_req = 0; dir_c = 0; ack_c = 0; wd_c = 0;
        while ((got == 0) && (idx <= 200)) begin
            ssg_done  = 1'b0;
            xfer_done = 1'b0;
            if (bus.rsp_valid) begin
                got = 1;
            end else begin
                if (ssg_start || ssg_stop || xfer_req) begin
                    if (req_cycles == 0) begin
                        line_req = int'(line_sel);
                        dir_c    = int'(xfer_dir);
                        ack_c    = int'(xfer_ack_send);
                        wd_c     = int'(xfer_wdata);
                    end
                    req_cycles++;
                    last = idx;
                    mask = mask | int'({xfer_req, ssg_stop, ssg_start});
                    if (idx == v.done_at) begin
                        ssg_done  = ssg_start | ssg_stop;
                        xfer_done = xfer_req;
                    end
                end
                @(negedge clk);
                idx++;
            end
        end
        ssg_done  = 1'b0;
        xfer_done = 1'b0;
        chk("rsp_seen", got, 1);
        chk("rsp_latency", idx - last, 2);
        chk("req_cycles", req_cycles, v.exp_cycles);
        chk("req_mask", mask, v.exp_mask);
        chk("rsp_err", int'(bus.rsp_err), v.exp_err);
        chk("rsp_nack", int'(bus.rsp_nack), v.exp_nack);
        chk("rsp_data", int'(bus.rsp_data), v.exp_rdata);
        chk("bus_owned", int'(bus_owned), v.exp_owned);
        if (v.exp_cycles > 0) chk("line_sel_req", line_req, v.exp_line_req);
        if (v.exp_mask == 4) begin
            chk("xfer_dir", dir_c, (v.op == 2) ? 1 : 0);
            chk("xfer_ack_send", ack_c, v.mack);
            chk("xfer_wdata", wd_c, v.data);
        end
        $display("[TB] vec %0d op=%0d req_cycles=%0d err=%0b nack=%0b data=%02h owned=%0b",
                 id, v.op, req_cycles, bus.rsp_err, bus.rsp_nack, bus.rsp_data, bus_owned);
        // Backpressure: a pending command must not be taken while the response waits.
        bus.cmd_valid = (v.hold > 0);
        bus.cmd_op    = CMD_START;
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            chk("hold_cmd_ready", int'(bus.cmd_ready), 0);
            chk("hold_rsp_valid", int'(bus.rsp_valid), 1);
            chk("hold_rsp_err", int'(bus.rsp_err), v.exp_err);
            chk("hold_rsp_nack", int'(bus.rsp_nack), v.exp_nack);
        end
        bus.rsp_ready = 1'b1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("rsp_valid_after", int'(bus.rsp_valid), 0);
        chk("cmd_ready_after", int'(bus.cmd_ready), 1);
        chk("line_sel_idle", int'(line_sel), v.exp_line_idle);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            op data  mk done rdata ack hold  mask cyc err nack rdat own lreq lidle
        vecs[0]  = '{1, 'h11, 0, 0,  'h00, 0, 0,   0,   0, 1,  0,  'h00, 0, 0, 0};
        vecs[1]  = '{3, 'h00, 0, 0,  'h00, 0, 0,   0,   0, 1,  0,  'h00, 0, 0, 0};
        vecs[2]  = '{2, 'h00, 1, 0,  'h77, 0, 0,   0,   0, 1,  0,  'h00, 0, 0, 0};
        vecs[3]  = '{0, 'h00, 0, 10, 'h00, 0, 0,   1,  10, 0,  0,  'h00, 1, 1, 1};
        vecs[4]  = '{1, 'hA5, 0, 5,  'h00, 1, 5,   4,   5, 0,  1,  'h00, 1, 2, 2};
        vecs[5]  = '{2, 'h00, 1, 3,  'h3C, 0, 0,   4,   3, 0,  0,  'h3C, 1, 2, 2};
        vecs[6]  = '{1, 'h5A, 0, 1,  'h00, 0, 0,   4,   1, 0,  0,  'h00, 1, 2, 2};
        vecs[7]  = '{0, 'h00, 0, 2,  'h00, 0, 0,   1,   2, 0,  0,  'h00, 1, 1, 1};
        vecs[8]  = '{3, 'h00, 0, 4,  'h00, 0, 0,   2,   4, 0,  0,  'h00, 0, 1, 0};
        vecs[9]  = '{0, 'h00, 0, 0,  'h00, 0, 0,   1,  16, 1,  0,  'h00, 0, 1, 0};
        vecs[10] = '{0, 'h00, 0, 16, 'h00, 0, 0,   1,  16, 0,  0,  'h00, 1, 1, 1};
        vecs[11] = '{2, 'h00, 0, 0,  'hC3, 0, 0,   4,  16, 1,  0,  'h00, 0, 2, 0};
        vecs[12] = '{1, 'h22, 0, 0,  'h00, 0, 2,   0,   0, 1,  0,  'h00, 0, 0, 0};
        vecs[13] = '{0, 'h00, 0, 1,  'h00, 0, 0,   1,   1, 0,  0,  'h00, 1, 1, 1};

        rst = 1'b1;
        ssg_done = 1'b0; xfer_done = 1'b0; xfer_rdata = 8'h00; xfer_ack_rcvd = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_op = CMD_START; bus.cmd_data = 8'h00;
        bus.cmd_master_ack = 1'b0; bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", int'(bus.cmd_ready), 0);
        chk("rst_outputs", int'({bus.rsp_valid, bus.rsp_err, bus.rsp_nack, bus_owned,
                                 ssg_start, ssg_stop, xfer_req, xfer_dir, xfer_ack_send}), 0);
        chk("rst_rsp_data", int'(bus.rsp_data), 0);
        chk("rst_xfer_wdata", int'(xfer_wdata), 0);
        chk("rst_line_sel", int'(line_sel), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

        // Reset in the middle of a byte transfer drops the request with no response.
        bus.cmd_valid = 1'b1; bus.cmd_op = CMD_WRITE; bus.cmd_data = 8'h99;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("midxfer_req_before", int'(xfer_req), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midxfer_req_after_rst", int'(xfer_req), 0);
        chk("midxfer_owned_after_rst", int'(bus_owned), 0);
        chk("midxfer_line_after_rst", int'(line_sel), 0);
        chk("midxfer_wdata_after_rst", int'(xfer_wdata), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("midxfer_no_rsp", int'(bus.rsp_valid), 0);
        chk("midxfer_cmd_ready", int'(bus.cmd_ready), 1);
        $display("[TB] reset mid-XFER: xfer_req=%0b rsp_valid=%0b", xfer_req, bus.rsp_valid);

        // Stray done pulses in IDLE must not change anything.
        ssg_done = 1'b1; xfer_done = 1'b1;
        @(negedge clk);
        ssg_done = 1'b0; xfer_done = 1'b0;
        @(negedge clk);
        chk("stray_done_owned", int'(bus_owned), 0);
        chk("stray_done_rsp", int'(bus.rsp_valid), 0);
        chk("stray_done_ready", int'(bus.cmd_ready), 1);
        $display("[TB] stray done in IDLE: owned=%0b rsp_valid=%0b", bus_owned, bus.rsp_valid);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/i2c_master_sequencer.md
Name: i2c_master_sequencer

Overview:
Command-level controller for the I2C master. It accepts START / WRITE / READ / STOP commands from the register interface and sequences the start/stop generator and the byte-transfer engine. It owns the SDA/SCL line-driver select and tracks bus ownership, so that writes or stops without a prior START are rejected. Each command produces exactly one response.

Parameters:
TIMEOUT_CYCLES, 65536, max cycles to wait for a sub-unit done before aborting (counter width = $clog2(TIMEOUT_CYCLES+1))

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  sequencer can accept a command
cmd_op  in  2  i2c_cmd_t: START=0, WRITE=1, READ=2, STOP=3
cmd_data  in  8  byte to write (WRITE only)
cmd_master_ack  in  1  ACK(0)/NACK(1) the master sends after READ
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_data  out  8  read byte (READ), else 0
rsp_nack  out  1  slave NACKed a WRITE
rsp_err  out  1  illegal command or timeout
bus_owned  out  1  master holds the bus (START issued, no STOP yet)
ssg_start  out  1  level request to start/stop generator
ssg_stop  out  1  level request to start/stop generator
ssg_done  in  1  generator sequence complete
xfer_req  out  1  level request to byte engine
xfer_dir  out  1  0=write, 1=read
xfer_wdata  out  8  byte to shift out
xfer_ack_send  out  1  ack bit the master drives after a read
xfer_done  in  1  byte engine complete
xfer_rdata  in  8  received byte
xfer_ack_rcvd  in  1  ack bit sampled after a write (1=NACK)
line_sel  out  2  line_sel_t: REL=0, SSG=1, XFER=2

Behaviour:
- Reset: state IDLE. All outputs are 0: cmd_ready, rsp_*, bus_owned, ssg_*, xfer_*, line_sel=REL. The timeout counter is 0.
- Reset asserted mid-operation drops every request at the next edge. No completion response is produced.
- cmd_ready=1 only in IDLE with rsp_valid=0. A command is accepted on the cycle with cmd_valid&cmd_ready. The op and data are registered at acceptance.
- States:
  - IDLE: on accept, go by op. START goes to GEN_START. STOP goes to GEN_STOP if bus_owned, else ERR. WRITE/READ go to XFER if bus_owned, else ERR.
  - GEN_START / GEN_STOP: ssg_start or ssg_stop=1, line_sel=SSG, held until ssg_done is sampled 1.
    - On done: START sets bus_owned=1; STOP clears it. Go to RELEASE.
    - START while already owned is a repeated start; no error.
  - XFER: xfer_req=1, line_sel=XFER, xfer_dir/wdata/ack_send driven from registered command. Held until xfer_done=1.
    - On done, latch xfer_rdata (READ) or xfer_ack_rcvd to rsp_nack (WRITE), then go to RELEASE.
  - RELEASE: one cycle with all requests 0 and line_sel unchanged, so the sub-units return to idle. Then go to RESP.
  - RESP: rsp_valid=1, held stable until rsp_ready. Return to IDLE on the cycle rsp_valid&rsp_ready.
  - ERR: all requests 0, rsp_err=1, go to RESP. No bus activity; bus_owned unchanged.
- Latency: the request asserts the cycle after acceptance. rsp_valid asserts 2 cycles after the done is sampled.
- Timeout:
  - The counter increments each cycle in GEN_START, GEN_STOP and XFER, and clears on entry to those states.
  - On reaching TIMEOUT_CYCLES without done, drop the request, clear bus_owned, set rsp_err, go to RELEASE then RESP.
  - If done and timeout occur in the same cycle, done wins.
- line_sel returns to REL in IDLE only when bus_owned=0. When owned, it holds its last value so that SCL stays low between bytes.
- rsp_nack does not clear bus_owned. Software issues STOP.
- A done pulse outside a waiting state is ignored.

Decomposition:
- Package i2c_seq_pkg holds:
  - i2c_cmd_t, line_sel_t
  - state enum seq_state_t (IDLE, GEN_START, GEN_STOP, XFER, RELEASE, RESP, ERR)
  - ACK/NACK bit constants
- The timeout counter uses the existing flex_counter with rollover_val=TIMEOUT_CYCLES and clear = not waiting. No other sub-module.

Test Plan:
- START, then ssg_done after 10 cycles: ssg_start high 10 cycles; rsp_valid 2 cycles after done with rsp_err=0; bus_owned=1.
- Owned bus, WRITE 0xA5, xfer_done with xfer_ack_rcvd=1: xfer_wdata=0xA5, xfer_dir=0; response rsp_nack=1, rsp_err=0.
- Owned bus, READ with cmd_master_ack=1, xfer_rdata=0x3C: xfer_dir=1, xfer_ack_send=1; response rsp_data=0x3C.
- WRITE or STOP after reset (not owned): no ssg/xfer request ever asserts; rsp_err=1 within 2 cycles of accept; bus_owned stays 0.
- TIMEOUT_CYCLES=16, START with ssg_done never asserted: request drops after 16 cycles; rsp_err=1; bus_owned=0. Also: done and timeout in the same cycle gives rsp_err=0.
- rsp_ready held 0 for 5 cycles with cmd_valid=1: cmd_ready stays 0 and the response stays stable. Also: rst asserted mid-XFER clears xfer_req at the next edge.
